// File: rtl/erode_pkg.sv
// Shared types and constants for the streaming 3x3 erosion block.
package erode_pkg;

    localparam int unsigned CW           = 11;
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;

    // Line-buffer entry: {row v-2, row v-1}
    typedef logic [1:0] lb_word_t;

    // 3x3 window, [col][row]; col 0 = newest (right), row 0 = row v (bottom)
    typedef logic [2:0][2:0] win_t;

endpackage

// File: rtl/erode_line_buffer.sv
// Two-row line buffer: synchronous RAM, one read and one write port,
// read returns the pre-write contents on an address collision.
module erode_line_buffer
    import erode_pkg::*;
#(
    parameter int unsigned DEPTH = H_ACTIVE_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] rd_addr,
    output lb_word_t      rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  lb_word_t      wr_data
);

    lb_word_t mem [DEPTH];

    // registered read and write; no reset on RAM contents
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/erode.sv
// Streaming 3x3 binary erosion on a raster-indexed edge stream.
// Build option: define ERODE_CROSS_EN for a plus-shaped kernel
// (centre and 4 orthogonal neighbours); default is the full 3x3 square.
module erode
    import erode_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] hcount,
    input  logic [CW-1:0] vcount,
    input  logic          edge_value,
    output logic          erode_value,
    output logic [CW-1:0] erode_hcount,
    output logic [CW-1:0] erode_vcount,
    output logic          erode_valid
);

    localparam int unsigned   AW     = $clog2(H_ACTIVE);
    localparam logic [CW-1:0] H_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_LAST = CW'(H_ACTIVE - 1);

    logic [CW-1:0]   h_q;
    logic [CW-1:0]   v_q;
    logic            e_q;
    logic [AW-1:0]   rd_addr;
    lb_word_t        rd_data;
    lb_word_t        wr_data;
    logic            wr_en;
    logic [1:0][2:0] hist;
    win_t            win_nxt;
    win_t            kern;
    logic [2:0]      col_new;
    logic [1:0]      fill;
    logic [1:0]      fill_eff;
    logic [1:0]      fill_nxt;
    logic            col_active;
    logic            row_active;
    logic            centre_valid;
    logic            kernel_and;

    // read the stored rows for the incoming column; out-of-area columns park at 0
    always_comb begin
        rd_addr = '0;
        if (hcount < H_END) begin
            rd_addr = AW'(hcount);
        end
    end

    erode_line_buffer #(
        .DEPTH (H_ACTIVE),
        .AW    (AW)
    ) u_line_buffer (
        .clk     (clk),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (AW'(h_q)),
        .wr_data (wr_data)
    );

    // capture raster position and pixel alongside the RAM read; all-ones
    // position after reset lies outside the active area
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q <= '1;
            v_q <= '1;
            e_q <= 1'b0;
        end else begin
            h_q <= hcount;
            v_q <= vcount;
            e_q <= edge_value;
        end
    end

    // build the new column, update fill, write back, evaluate the kernel
    always_comb begin
        col_active = (h_q < H_END);
        row_active = (v_q < V_END);
        fill_eff   = fill;
        if (h_q == '0 && v_q == '0) begin
            fill_eff = 2'd0;
        end

        col_new = '0;
        if (col_active) begin
            col_new[0] = row_active & e_q;
            col_new[1] = (fill_eff >= 2'd1) & rd_data[0];
            col_new[2] = (fill_eff >= 2'd2) & rd_data[1];
        end

        wr_en   = col_active & row_active;
        wr_data = {rd_data[0], e_q};

        fill_nxt = fill_eff;
        if (wr_en && h_q == H_LAST && fill_eff != 2'd2) begin
            fill_nxt = fill_eff + 2'd1;
        end

        win_nxt = {hist[1], hist[0], col_new};
        kern    = win_nxt;
        // centre column 0: the left column is the previous line's tail
        if (h_q == CW'(1)) begin
            kern[2] = '0;
        end

        centre_valid = (h_q != '0) && (h_q <= H_END) &&
                       (v_q != '0) && (v_q <= V_END);
`ifdef ERODE_CROSS_EN
        kernel_and = kern[1][2] & kern[1][1] & kern[1][0] & kern[0][1] & kern[2][1];
`else
        kernel_and = &kern;
`endif
    end

    // window history, fill counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist         <= '0;
            fill         <= 2'd0;
            erode_value  <= 1'b0;
            erode_valid  <= 1'b0;
            erode_hcount <= '0;
            erode_vcount <= '0;
        end else begin
            hist         <= {win_nxt[1], win_nxt[0]};
            fill         <= fill_nxt;
            erode_valid  <= centre_valid;
            erode_value  <= centre_valid & kernel_and;
            erode_hcount <= h_q - CW'(1);
            erode_vcount <= v_q - CW'(1);
        end
    end

endmodule
